// File: rtl/encoder_ctrl.sv
// rtl/encoder_ctrl.sv - host-to-encoder message sequencer with index forwarding, weight check and watchdog
module encoder_ctrl #(
  parameter int MSG_BYTES = 40,
  parameter int CW_WIDTH  = 10,
  parameter int WEIGHT    = 38,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                abort,
  input  logic                msg_valid,
  input  logic [7:0]          msg_byte,
  output logic                msg_ready,
  output logic                enc_wr_en,
  output logic [7:0]          enc_msg_bype,
  output logic                enc_start,
  input  logic [CW_WIDTH-1:0] enc_cw_out,
  input  logic                enc_cw_rdy,
  input  logic                enc_cw_done,
  output logic                cw_valid,
  output logic [CW_WIDTH-1:0] cw_index,
  output logic [7:0]          cw_count,
  output logic                busy,
  output logic                done,
  output logic                err_weight,
  output logic                err_timeout
);

  localparam int BW = $clog2(MSG_BYTES + 1);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DONE} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   byte_cnt;
  logic [WW-1:0]   wdog;
  logic            ready_q;
  logic            xfer;
  logic            run_strobe;
  logic [7:0]      cnt_inc;
  logic [7:0]      cnt_final;

  // ready is a flop so it reads 0 during reset; abort still blocks a transfer the same cycle
  assign msg_ready  = ready_q & ~abort;
  assign xfer       = msg_valid & msg_ready;
  assign busy       = (state != S_IDLE);
  assign run_strobe = (state == S_RUN) & enc_cw_rdy & ~abort;
  assign cnt_inc    = (cw_count == 8'hFF) ? cw_count : cw_count + 8'd1;
  assign cnt_final  = enc_cw_rdy ? cnt_inc : cw_count;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (xfer) state_nx = (MSG_BYTES == 1) ? S_START : S_LOAD;
        S_LOAD:  if (xfer && byte_cnt == BW'(MSG_BYTES - 1)) state_nx = S_START;
        S_START: state_nx = S_RUN;
        S_RUN: begin
          if (enc_cw_done)      state_nx = S_DONE;
          else if (wdog == '0)  state_nx = S_IDLE;
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      byte_cnt     <= '0;
      wdog         <= '0;
      enc_wr_en    <= 1'b0;
      enc_msg_bype <= 8'h00;
      enc_start    <= 1'b0;
      cw_valid     <= 1'b0;
      cw_index     <= '0;
      cw_count     <= 8'h00;
      done         <= 1'b0;
      err_weight   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state     <= state_nx;
      ready_q   <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
      enc_wr_en <= xfer;
      if (xfer) enc_msg_bype <= msg_byte;
      enc_start <= (state == S_START) && !abort;
      done      <= (state_nx == S_DONE);
      cw_valid  <= run_strobe;
      if (run_strobe) begin
        cw_index <= enc_cw_out;
        cw_count <= cnt_inc;
      end

      // first byte of a message starts a fresh result record
      if (state == S_IDLE && xfer) begin
        byte_cnt    <= BW'(1);
        cw_count    <= 8'h00;
        err_weight  <= 1'b0;
        err_timeout <= 1'b0;
      end else if (state == S_LOAD && xfer) begin
        byte_cnt <= byte_cnt + BW'(1);
      end

      if (state == S_START)                   wdog <= WW'(TIMEOUT - 1);
      else if (state == S_RUN && wdog != '0)  wdog <= wdog - WW'(1);

      // done wins over an expiring watchdog in the same cycle
      if (state == S_RUN && !abort) begin
        if (enc_cw_done)      err_weight  <= err_weight | (cnt_final != 8'(WEIGHT));
        else if (wdog == '0)  err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encoder_ctrl.sv
// tb/tb_encoder_ctrl.sv - directed vector bench for encoder_ctrl with a model encoder
module tb_encoder_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       abort;
  logic       msg_valid;
  logic [7:0] msg_byte;
  logic [9:0] enc_cw_out;
  logic       enc_cw_rdy;
  logic       enc_cw_done;

  logic       msg_ready, enc_wr_en, enc_start, cw_valid, busy, done, err_weight, err_timeout;
  logic [7:0] enc_msg_bype, cw_count;
  logic [9:0] cw_index;

  logic       t_msg_ready, t_enc_wr_en, t_enc_start, t_cw_valid, t_busy, t_done, t_err_weight, t_err_timeout;
  logic [7:0] t_enc_msg_bype, t_cw_count;
  logic [9:0] t_cw_index;

  always #5 clk = ~clk;

  encoder_ctrl u_dut (
    .clk(clk), .rst_b(rst_b), .abort(abort), .msg_valid(msg_valid), .msg_byte(msg_byte),
    .msg_ready(msg_ready), .enc_wr_en(enc_wr_en), .enc_msg_bype(enc_msg_bype), .enc_start(enc_start),
    .enc_cw_out(enc_cw_out), .enc_cw_rdy(enc_cw_rdy), .enc_cw_done(enc_cw_done),
    .cw_valid(cw_valid), .cw_index(cw_index), .cw_count(cw_count), .busy(busy), .done(done),
    .err_weight(err_weight), .err_timeout(err_timeout)
  );

  encoder_ctrl #(.TIMEOUT(16)) u_to (
    .clk(clk), .rst_b(rst_b), .abort(abort), .msg_valid(msg_valid), .msg_byte(msg_byte),
    .msg_ready(t_msg_ready), .enc_wr_en(t_enc_wr_en), .enc_msg_bype(t_enc_msg_bype), .enc_start(t_enc_start),
    .enc_cw_out(enc_cw_out), .enc_cw_rdy(enc_cw_rdy), .enc_cw_done(enc_cw_done),
    .cw_valid(t_cw_valid), .cw_index(t_cw_index), .cw_count(t_cw_count), .busy(t_busy), .done(t_done),
    .err_weight(t_err_weight), .err_timeout(t_err_timeout)
  );

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    bit         stall;
    int         n_idx;
    bit         same;
    logic [7:0] exp_count;
    bit         exp_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_n, wr_bad, start_n, start_cyc, last_wr_cyc, cv_n, idx_bad, done_n, t_done_n;
  bit exp_wr = 1'b0;
  logic [7:0] wr_log [64];
  logic [9:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    wr_n = 0; wr_bad = 0; start_n = 0; start_cyc = 0; last_wr_cyc = 0;
    cv_n = 0; idx_bad = 0; done_n = 0; t_done_n = 0;
    exp_q.delete();
  endtask

  // advance to the next falling edge and log everything the main DUT emitted
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (enc_wr_en) begin
      if (wr_n < 64) wr_log[wr_n] = enc_msg_bype;
      wr_n++;
      last_wr_cyc = cyc;
      if (!exp_wr) wr_bad++;
    end else if (exp_wr) begin
      wr_bad++;
    end
    if (enc_start) begin
      start_n++;
      start_cyc = cyc;
    end
    if (cw_valid) begin
      cv_n++;
      if (exp_q.size() == 0) idx_bad++;
      else begin
        if (exp_q[0] !== cw_index) idx_bad++;
        void'(exp_q.pop_front());
      end
    end
    if (done) done_n++;
    if (t_done) t_done_n++;
  endtask

  task automatic send_msg(input logic [7:0] base, input logic [7:0] step, input bit stall, input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 400) begin
      if (stall && (g % 2) == 1) begin
        msg_valid = 1'b0;
      end else begin
        msg_valid = 1'b1;
        msg_byte  = 8'(int'(base) + int'(step) * i);
      end
      exp_wr = msg_valid && msg_ready;
      if (exp_wr) i++;
      tick();
      g++;
    end
    msg_valid = 1'b0;
    exp_wr    = 1'b0;
    check("bytes_accepted", 64'(i), 64'(n));
  endtask

  task automatic wait_start();
    int g = 0;
    while (start_n == 0 && g < 10) begin
      tick();
      g++;
    end
    check("start_seen", 64'(start_n), 64'd1);
  endtask

  task automatic run_enc(input int n, input bit same, input logic [7:0] base);
    logic [9:0] idx;
    for (int k = 0; k < n; k++) begin
      idx = 10'((k * 37 + int'(base) * 3) % 1024);
      enc_cw_rdy = 1'b1;
      enc_cw_out = idx;
      exp_q.push_back(idx);
      if (same && k == n - 1) enc_cw_done = 1'b1;
      tick();
    end
    enc_cw_rdy = 1'b0;
    if (!same || n == 0) begin
      enc_cw_done = 1'b1;
      tick();
    end
    enc_cw_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int byte_bad = 0;
    clear_counts();
    send_msg(v.base, v.step, v.stall, 40);
    check("err_weight_cleared", 64'(err_weight), 64'd0);
    check("wr_count", 64'(wr_n), 64'd40);
    check("wr_only_on_xfer", 64'(wr_bad), 64'd0);
    for (int k = 0; k < 40; k++)
      if (wr_log[k] !== 8'(int'(v.base) + int'(v.step) * k)) byte_bad++;
    check("wr_bytes", 64'(byte_bad), 64'd0);
    wait_start();
    check("start_after_last_wr", 64'(start_cyc), 64'(last_wr_cyc + 1));
    run_enc(v.n_idx, v.same, v.base);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd1);
    check("cw_count", 64'(cw_count), 64'(v.exp_count));
    check("err_weight", 64'(err_weight), 64'(v.exp_err));
    tick();
    tick();
    check("busy_after", 64'(busy), 64'd0);
    check("done_once", 64'(done_n), 64'd1);
    check("cw_valid_count", 64'(cv_n), 64'(v.n_idx));
    check("cw_index_match", 64'(idx_bad), 64'd0);
    check("err_timeout_main", 64'(err_timeout), 64'd0);
  endtask

  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL sim_watchdog: got no finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int to_k;
    logic t_busy_at;
    vecs[0] = '{base: 8'h40, step: 8'h15, stall: 1'b0, n_idx: 38, same: 1'b0, exp_count: 8'd38, exp_err: 1'b0};
    vecs[1] = '{base: 8'h00, step: 8'h01, stall: 1'b1, n_idx: 38, same: 1'b0, exp_count: 8'd38, exp_err: 1'b0};
    vecs[2] = '{base: 8'h80, step: 8'h07, stall: 1'b0, n_idx: 37, same: 1'b0, exp_count: 8'd37, exp_err: 1'b1};
    vecs[3] = '{base: 8'hF0, step: 8'h03, stall: 1'b0, n_idx: 38, same: 1'b1, exp_count: 8'd38, exp_err: 1'b0};
    vecs[4] = '{base: 8'h11, step: 8'h0B, stall: 1'b0, n_idx: 39, same: 1'b1, exp_count: 8'd39, exp_err: 1'b1};
    vecs[5] = '{base: 8'h22, step: 8'h05, stall: 1'b0, n_idx: 0,  same: 1'b0, exp_count: 8'd0,  exp_err: 1'b1};

    rst_b = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_byte = 8'h00;
    enc_cw_out = '0; enc_cw_rdy = 1'b0; enc_cw_done = 1'b0;
    clear_counts();
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {msg_ready, enc_wr_en, enc_msg_bype, enc_start, cw_valid, cw_index, cw_count, busy, done, err_weight, err_timeout},
          64'd0);
    rst_b = 1'b1;

    // reset in the middle of a load, then a full message must load from scratch
    send_msg(8'h10, 8'h01, 1'b0, 10);
    check("busy_mid_load", 64'(busy), 64'd1);
    check("wr_mid_load", 64'(wr_n), 64'd10);
    rst_b = 1'b0;
    #1;
    check("reset_mid_load_outputs",
          {msg_ready, enc_wr_en, enc_msg_bype, enc_start, cw_valid, cw_index, cw_count, busy, done, err_weight, err_timeout},
          64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // watchdog expiry on the TIMEOUT=16 instance
    clear_counts();
    send_msg(8'h33, 8'h01, 1'b0, 40);
    wait_start();
    to_k = 0;
    t_busy_at = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (t_err_timeout && to_k == 0) begin
        to_k = k;
        t_busy_at = t_busy;
      end
    end
    check("timeout_cycle", 64'(to_k), 64'd16);
    check("timeout_busy", 64'(t_busy_at), 64'd0);
    check("timeout_no_done", 64'(t_done_n), 64'd0);
    enc_cw_done = 1'b1;
    tick();
    enc_cw_done = 1'b0;
    tick();
    tick();
    check("late_done_ignored", 64'(t_done_n), 64'd0);
    check("timeout_sticky", 64'(t_err_timeout), 64'd1);
    check("timeout_idle", 64'(t_busy), 64'd0);

    // abort in RUN alongside an index strobe
    clear_counts();
    send_msg(8'h5A, 8'h03, 1'b0, 40);
    wait_start();
    run_enc(0, 1'b0, 8'h00);
    repeat (1) tick();
    clear_counts();
    send_msg(8'h5A, 8'h03, 1'b0, 40);
    wait_start();
    for (int k = 0; k < 5; k++) begin
      enc_cw_rdy = 1'b1;
      enc_cw_out = 10'(100 + k);
      exp_q.push_back(10'(100 + k));
      tick();
    end
    enc_cw_out = 10'h3FF;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    enc_cw_rdy = 1'b0;
    check("abort_no_cw_valid", 64'(cw_valid), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_cw_count_kept", 64'(cw_count), 64'd5);
    check("abort_valid_count", 64'(cv_n), 64'd5);
    enc_cw_done = 1'b1;
    tick();
    enc_cw_done = 1'b0;
    tick();
    check("abort_no_done", 64'(done_n), 64'd0);
    check("abort_still_idle", 64'(busy), 64'd0);

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_ctrl.md
Name: encoder_ctrl

Overview:
- Sequencer wrapped around encoder_top for the constant-weight coding path.
- Accepts message bytes from a host over a valid/ready stream and replays them into the encoder as a contiguous wr_en burst, one byte per cycle.
- Pulses start, then forwards each codeword index to the sink and checks the index count against the expected weight.
- Guards the encode with a watchdog and reports completion and errors to the host.

Parameters:
MSG_BYTES, 40, bytes per message loaded into the encoder
CW_WIDTH, 10, width of a codeword index (enc_cw_out)
WEIGHT, 38, expected number of cw_rdy strobes per message
TIMEOUT, 4096, max cycles from start pulse to enc_cw_done

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  asynchronous active-low reset
abort  in  1  synchronous abort; returns FSM to IDLE
msg_valid  in  1  host byte valid
msg_byte  in  8  host message byte, MSB-first order
msg_ready  out  1  controller accepts byte this cycle
enc_wr_en  out  1  encoder byte write strobe
enc_msg_bype  out  8  encoder byte bus
enc_start  out  1  one-cycle encode start pulse
enc_cw_out  in  CW_WIDTH  encoder codeword index
enc_cw_rdy  in  1  encoder index strobe
enc_cw_done  in  1  encoder finished
cw_valid  out  1  forwarded index valid (one cycle, no backpressure)
cw_index  out  CW_WIDTH  forwarded index
cw_count  out  8  indices received this message
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse, message encoded cleanly
err_weight  out  1  sticky: cw_count != WEIGHT at done
err_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (rst_b low, async): every output is 0 and the FSM is in IDLE. Sticky flags are cleared only by reset or by the first byte accepted in IDLE.
- Host handshake: a transfer occurs when msg_valid and msg_ready are both high.
- IDLE: msg_ready = 1. A transfer clears cw_count and both sticky flags, writes the byte to enc_msg_bype with enc_wr_en = 1 on the next cycle, sets byte_cnt = 1 and moves to LOAD.
- LOAD: msg_ready = 1. Each transfer drives enc_wr_en = 1 and enc_msg_bype = msg_byte on the following cycle and increments byte_cnt. Cycles with no transfer drive enc_wr_en = 0, so gaps are allowed.
  - At the transfer where byte_cnt reaches MSG_BYTES, drop msg_ready and go to START.
- START: single cycle. enc_start = 1, arriving the cycle after the last enc_wr_en. Watchdog loads TIMEOUT-1. Go to RUN.
- RUN: msg_ready = 0.
  - Each enc_cw_rdy produces cw_valid = 1 and cw_index = enc_cw_out one cycle later (registered), and increments cw_count.
  - cw_count saturates at 255.
  - Watchdog decrements every cycle.
- Exit from RUN:
  - enc_cw_done: go to DONE. A cw_rdy arriving in the same cycle is still counted.
  - Watchdog reaches 0 without done: set err_timeout and go to IDLE. No done pulse.
- DONE: single cycle. done = 1. err_weight is set if the final cw_count (including a same-cycle strobe) != WEIGHT. Go to IDLE.
- Back-to-back messages: a new message may start the cycle after DONE. cw_count holds its value until the next message's first byte.
- Abort: in any state, takes priority over all other events. Go to IDLE with enc_wr_en and enc_start forced to 0, and no done pulse. Flags and cw_count are kept.
- Encoder strobes outside RUN: enc_cw_rdy and enc_cw_done are ignored.
- busy = (state != IDLE).
- Encoder-side outputs are registered, with no combinational path from the host inputs.

Test Plan:
- Reset mid-LOAD: after 10 bytes, pulse rst_b low -> all outputs 0 immediately; the next 40 bytes load normally from byte_cnt 0.
- Nominal: 40 back-to-back bytes 0x40,0x55,... -> 40 consecutive enc_wr_en cycles with matching bytes, then enc_start exactly 1 cycle after the last write. A model encoder issues 38 cw_rdy then cw_done -> 38 cw_valid, cw_count = 38, done pulse, err_weight = 0.
- Stalled host: msg_valid toggled every other cycle -> enc_wr_en is high only on transfer cycles, still 40 in total, start issued once.
- Weight mismatch: model emits 37 indices then cw_done -> done pulse, err_weight = 1, cw_count = 37; err_weight clears on the next message's first byte.
- Timeout: TIMEOUT = 16 and the encoder never asserts done -> err_timeout = 1 on the 16th RUN cycle, busy = 0, no done; cw_done asserted later is ignored.
- Simultaneous events: cw_rdy coincides with cw_done -> counted, cw_count = 38, no error. abort asserted in RUN alongside cw_rdy -> back to IDLE, no cw_valid, no done.
